// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the factorial CPU result consumer
//   stateT                  capture FSM states
//   W_DATA / ND_BCD         binary result width / number of BCD digits
//   DIGIT_W, *_LSB          BCD digit field width and positions within bcd_digits
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} stateT;
    localparam int W_DATA   = 8;
    localparam int ND_BCD   = 3;
    localparam int DIGIT_W  = 4;
    localparam int ONES_LSB = 0;
    localparam int TENS_LSB = 4;
    localparam int HUND_LSB = 8;
endpackage

// File: rtl/result_bcd_capture_if.sv
// result_bcd_capture_if: CPU result input and BCD display handshake bundle
//   cpu_busy, cpu_out       CPU busy flag and result bus
//   bcd_digits, bcd_valid   converted digits and their valid flag
//   bcd_ready               consumer accepts bcd_digits
//   conv_active, overrun    engine busy status and sticky lost-result flag
//   master: the CPU/display side; slave: the capture block
interface result_bcd_capture_if #(parameter int W = 8, parameter int ND = 3);
    logic            cpu_busy;
    logic [W-1:0]    cpu_out;
    logic [4*ND-1:0] bcd_digits;
    logic            bcd_valid;
    logic            bcd_ready;
    logic            conv_active;
    logic            overrun;
    modport master (output cpu_busy, cpu_out, bcd_ready, input bcd_digits, bcd_valid, conv_active, overrun);
    modport slave (input cpu_busy, cpu_out, bcd_ready, output bcd_digits, bcd_valid, conv_active, overrun);
endinterface

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble step (add-3 per nibble, then shift left)
//   bcdIn, binIn    current BCD and binary shift registers
//   bcdOut, binOut  register values after this step
module bcd_dabble_step import cpu_pkg::*; #(
    parameter int W  = W_DATA,
    parameter int ND = ND_BCD
) (
    input  logic [DIGIT_W*ND-1:0] bcdIn,
    input  logic [W-1:0]          binIn,
    output logic [DIGIT_W*ND-1:0] bcdOut,
    output logic [W-1:0]          binOut
);
    logic [DIGIT_W*ND-1:0] adj;
    // nibbles never exceed 9, so the 4-bit add-3 cannot overflow
    for (genvar i = 0; i < ND; i++) begin : gAdj
        assign adj[DIGIT_W*i +: DIGIT_W] = (bcdIn[DIGIT_W*i +: DIGIT_W] >= 4'd5) ?
            bcdIn[DIGIT_W*i +: DIGIT_W] + 4'd3 : bcdIn[DIGIT_W*i +: DIGIT_W];
    end
    assign {bcdOut, binOut} = {adj, binIn} << 1;
endmodule

// File: rtl/result_bcd_capture.sv
// result_bcd_capture: captures the CPU result when busy falls and presents it as BCD digits
//   clk, reset   clock and synchronous active-high reset
//   bus (slave)  cpu_busy/cpu_out in; bcd_digits/bcd_valid/bcd_ready handshake;
//                conv_active while converting; overrun sticky when a result is dropped
module result_bcd_capture import cpu_pkg::*; #(
    parameter int W  = W_DATA,
    parameter int ND = ND_BCD
) (
    input logic                  clk,
    input logic                  reset,
    result_bcd_capture_if.slave  bus
);
    localparam int CW = $clog2(W);
    stateT           state, stateNext;
    logic            busyD, capture, start, finish;
    logic            pendFull, pendFullNext, overrunR, overrunNext;
    logic [W-1:0]    pendVal, pendValNext, startVal, binSr, stepBin;
    logic [4*ND-1:0] bcdSr, stepBcd, digits;
    logic [CW-1:0]   cnt;
    logic            valid;
    assign capture = busyD & ~bus.cpu_busy;
    bcd_dabble_step #(.W(W), .ND(ND)) uStep (
        .bcdIn (bcdSr),
        .binIn (binSr),
        .bcdOut(stepBcd),
        .binOut(stepBin)
    );
    always_ff @(posedge clk)
        state <= reset ? IDLE : stateNext;
    always_comb begin
        stateNext    = state;
        start        = 1'b0;
        startVal     = bus.cpu_out;
        finish       = 1'b0;
        pendFullNext = pendFull;
        pendValNext  = pendVal;
        overrunNext  = overrunR;
        case (state)
            IDLE: begin
                if (capture) begin
                    start     = 1'b1;
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(W - 1)) begin
                    finish    = 1'b1;
                    stateNext = HOLD;
                end
                if (capture && !pendFull) begin
                    pendFullNext = 1'b1;
                    pendValNext  = bus.cpu_out;
                end else if (capture) begin
                    overrunNext = 1'b1;
                end
            end
            HOLD: begin
                if (bus.bcd_ready) begin
                    // a waiting result goes first; a coinciding capture takes its slot
                    if (pendFull) begin
                        start        = 1'b1;
                        startVal     = pendVal;
                        stateNext    = SHIFT;
                        pendFullNext = capture;
                        pendValNext  = capture ? bus.cpu_out : pendVal;
                    end else if (capture) begin
                        start     = 1'b1;
                        stateNext = SHIFT;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (capture && !pendFull) begin
                    pendFullNext = 1'b1;
                    pendValNext  = bus.cpu_out;
                end else if (capture) begin
                    overrunNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            busyD    <= 1'b0;
            binSr    <= '0;
            bcdSr    <= '0;
            cnt      <= '0;
            digits   <= '0;
            valid    <= 1'b0;
            pendFull <= 1'b0;
            pendVal  <= '0;
            overrunR <= 1'b0;
        end else begin
            busyD    <= bus.cpu_busy;
            pendFull <= pendFullNext;
            pendVal  <= pendValNext;
            overrunR <= overrunNext;
            if (start) begin
                binSr <= startVal;
                bcdSr <= '0;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                binSr <= stepBin;
                bcdSr <= stepBcd;
                cnt   <= cnt + 1'b1;
            end
            if (finish) begin
                digits <= stepBcd;
                valid  <= 1'b1;
            end else if (state == HOLD && bus.bcd_ready) begin
                valid <= 1'b0;
            end
        end
    end
    assign bus.bcd_digits  = digits;
    assign bus.bcd_valid   = valid;
    assign bus.conv_active = (state == SHIFT);
    assign bus.overrun     = overrunR;
endmodule
